prog_chain_loader: RTL
======================

# prog_chain_loader

Drives the configuration shift chain formed by the fabric's programmable muxes: the loader is the writer, and each mux cell is a shift-register reader. It accepts a configuration bitstream as a stream of W-bit words over a valid/ready handshake and serializes it onto `prog_in`/`prog_en`, one bit per clock, for exactly CHAIN_LEN bits. It can optionally run a non-destructive verify pass that rotates the chain through `prog_out` and compares CRC signatures. It sits between the configuration host interface and the head of the fabric's `prog_in` chain.

## Interface
- `CHAIN_LEN`, 64: total configuration bits in the chain (sum of all cells' SEL), ≥ 2
- `W`, 8: input word width, ≥ 2
- `clk` input 1: single clock; the fabric `prog_clk` is tied to this same net
- `rst_n` input 1: asynchronous, active-low reset
- `start` input 1: one-cycle pulse; begins a load, sampled only in IDLE
- `verify` input 1: sampled with `start`; 1 means a verify pass runs after the load
- `s_data` input W: bitstream word, MSB shifted first
- `s_valid` input 1: `s_data` is valid
- `s_ready` output 1: loader accepts a word this cycle
- `prog_in` output 1: serial bit into the chain head
- `prog_en` output 1: chain shift enable
- `prog_out` input 1: serial bit from the chain tail
- `busy` output 1: high from the cycle after `start` until `done`
- `done` output 1: one-cycle pulse at completion
- `crc_ok` / `crc_err` output 1: verify result, held until the next `start`

## Operation
- **Bit order.** The first bit shifted ends up in the cell farthest from the head, so the host supplies the bitstream tail-cell first. Within a word, the MSB goes first.
- **States:** IDLE, FETCH, SHIFT, VERIFY, DONE.
- **IDLE**
  - On `start`: clear the bit counter, both CRC registers, `crc_ok` and `crc_err`.
  - Latch `verify`, then go to FETCH.
- **FETCH**
  - `s_ready`=1.
  - On `s_valid`: load the shift buffer with `s_data`, set the word-bit count to min(W, remaining), go to SHIFT.
  - While `s_valid`=0: wait; `prog_en`=0.
- **SHIFT**
  - Each cycle: `prog_en`=1, `prog_in`=buffer MSB, buffer shifts left, and the TX CRC absorbs the bit.
  - When the word is exhausted and bits remain: go to FETCH.
  - When all CHAIN_LEN bits have been sent: go to VERIFY if `verify` was latched, else DONE.
  - For the final partial word (CHAIN_LEN mod W ≠ 0), only the upper CHAIN_LEN mod W bits are shifted and the low bits are discarded.
- **VERIFY**
  - Runs CHAIN_LEN cycles with `prog_en`=1 and `prog_in`=`prog_out` (loopback rotation). The chain contents are unchanged at the end.
  - The RX CRC absorbs `prog_out` each cycle; the sequence must equal the load sequence in order.
  - On the last cycle, go to DONE.
- **DONE**
  - `done` pulses for one cycle. If a verify pass ran, set `crc_ok` (RX==TX) or `crc_err` (RX≠TX).
  - Go to IDLE.
- **CRC:** CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, serial, no reflection, no final XOR.
- **Ignored inputs:** `start` is ignored outside IDLE. `s_valid` outside FETCH is ignored and the word is not consumed.
- **Counters:** the bit counter is $clog2(CHAIN_LEN+1) bits wide and never wraps. Entering a terminal state compares it to CHAIN_LEN.

## Timing
- All outputs are registered except `s_ready`, which decodes the FETCH state combinationally.
- Reset values: `prog_en`=0, `prog_in`=0, `s_ready`=0, `busy`=0, `done`=0, `crc_ok`=0, `crc_err`=0, state=IDLE.
- Reset asserted mid-operation: `prog_en` drops asynchronously. The chain contents are undefined and the host must reload.
- `start` at cycle 0 puts the loader in FETCH at cycle 1. Each word costs 1 FETCH cycle plus its SHIFT cycles, so the minimum load time is CHAIN_LEN + ceil(CHAIN_LEN/W) cycles.
- `prog_en` is high for exactly CHAIN_LEN cycles, or 2·CHAIN_LEN cycles with verify. It is never high in FETCH, IDLE or DONE.
- `done` occurs 1 cycle after the last `prog_en`=1 cycle. `busy` falls in the same cycle `done` pulses.
- Handshake: exactly one word is consumed per FETCH cycle with `s_valid`=1.

## Structure
- `prog_pkg`: state enum, CRC_POLY=16'h1021, CRC_INIT=16'hFFFF.
- Sub-module `prog_crc16`: serial CRC step with `clr`/`en`/`bit` inputs. It is instantiated twice, once for TX and once for RX.

## Test plan
- **Basic load.** CHAIN_LEN=16, W=8, words 0xA5 then 0x3C, `s_valid` always high, no verify. Required: `prog_en` high 16 cycles; chain model (four 4-bit cells) holds tail→head 1010,0101,0011,1100; `done` at cycle 19.
- **Backpressure.** Same stream with `s_valid` low for 5 cycles between the words. Required: `prog_en` low for those cycles; the chain result is identical; `done` is 5 cycles later.
- **Partial word.** CHAIN_LEN=12, W=8, words 0xFF, 0x9F. Required: 12 shifts; the last 4 bits are 1001; the low nibble 0xF is never shifted; exactly 2 words are consumed.
- **Verify pass.** Basic load with `verify`=1 on a correct chain model. Required: 32 `prog_en` cycles; chain unchanged afterwards; `crc_ok`=1, `crc_err`=0.
- **Verify fault.** Chain model with one cell stuck-at-0. Required: `crc_err`=1, `crc_ok`=0.
- **Reset and ignored start.** `rst_n` pulsed low mid-SHIFT, then a fresh start. Required: all outputs return to reset values immediately; the new load completes normally. A `start` pulsed while busy has no effect.

Source files
------------

// File: rtl/prog_pkg.sv
// -----------------------------------------------------------------------------
// prog_pkg
// Shared definitions for the configuration-chain loader: the loader FSM state
// encoding, the CRC-16-CCITT constants and a single-bit CRC step function.
// -----------------------------------------------------------------------------
package prog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_VERIFY,
    ST_DONE
  } state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One serial CRC-16-CCITT step: MSB-first, no reflection.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return fb ? ({crc[14:0], 1'b0} ^ CRC_POLY) : {crc[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/prog_crc16.sv
// -----------------------------------------------------------------------------
// prog_crc16
// Serial CRC-16-CCITT accumulator (poly 0x1021, init 0xFFFF, no final XOR).
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : reload the register with CRC_INIT (has priority over en)
//   en         : absorb bit_in this cycle
//   bit_in     : serial data bit
//   crc        : current CRC value
// -----------------------------------------------------------------------------
module prog_crc16
  import prog_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC_INIT;
    end else if (en) begin
      crc_d = crc16_step(crc_q, bit_in);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/prog_chain_loader.sv
// -----------------------------------------------------------------------------
// prog_chain_loader
// Serializes a W-bit word stream onto the fabric configuration shift chain,
// exactly CHAIN_LEN bits, MSB of each word first. An optional verify pass
// rotates the chain once through prog_out and compares CRC signatures.
//   clk, rst_n        : clock (also the fabric prog_clk), async active-low reset
//   start, verify     : begin a load; verify selects the rotation pass
//   s_data/s_valid    : bitstream word handshake input
//   s_ready           : FETCH decode, a word is accepted this cycle
//   prog_in, prog_en  : serial data / shift enable to the chain head
//   prog_out          : serial data from the chain tail
//   busy, done        : activity flag and one-cycle completion pulse
//   crc_ok, crc_err   : verify result, held until the next start
// -----------------------------------------------------------------------------
module prog_chain_loader
  import prog_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int W         = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         verify,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic         prog_in,
  output logic         prog_en,
  input  logic         prog_out,
  output logic         busy,
  output logic         done,
  output logic         crc_ok,
  output logic         crc_err
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LEN_C = CW'(CHAIN_LEN);

  state_e         state_q, state_d;
  logic [W-1:0]   buf_q, buf_d;
  logic [CW-1:0]  word_left_q, word_left_d;  // bits still to shift after the current one
  logic [CW-1:0]  bit_cnt_q, bit_cnt_d;      // bits sent (SHIFT) or rotated (VERIFY)
  logic           verify_q, verify_d;
  logic           prog_en_q, prog_en_d;
  logic           prog_in_q, prog_in_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           crc_ok_q, crc_ok_d;
  logic           crc_err_q, crc_err_d;

  logic [31:0]    rem;
  logic [31:0]    wbits;
  logic           cnt_last;
  logic [15:0]    tx_crc, rx_crc;
  logic           crc_clr;

  assign cnt_last = (bit_cnt_q == LEN_C - 1'b1);
  assign crc_clr  = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    word_left_d = word_left_q;
    bit_cnt_d   = bit_cnt_q;
    verify_d    = verify_q;
    prog_en_d   = 1'b0;
    prog_in_d   = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    crc_ok_d    = crc_ok_q;
    crc_err_d   = crc_err_q;
    // Bits this word contributes: a full word, or the tail of the chain.
    rem   = 32'(CHAIN_LEN) - 32'(bit_cnt_q);
    wbits = (rem > 32'(W)) ? 32'(W) : rem;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          bit_cnt_d = '0;
          crc_ok_d  = 1'b0;
          crc_err_d = 1'b0;
          verify_d  = verify;
          busy_d    = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // The MSB goes straight to prog_in so the first SHIFT cycle drives it.
        if (s_valid) begin
          prog_en_d   = 1'b1;
          prog_in_d   = s_data[W-1];
          buf_d       = s_data << 1;
          word_left_d = CW'(wbits - 32'd1);
          state_d     = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (word_left_q != '0) begin
          prog_en_d   = 1'b1;
          prog_in_d   = buf_q[W-1];
          buf_d       = buf_q << 1;
          word_left_d = word_left_q - 1'b1;
        end else if (cnt_last) begin
          if (verify_q) begin
            prog_en_d = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_VERIFY;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_VERIFY: begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (cnt_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          prog_en_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (verify_q) begin
          crc_ok_d  = (tx_crc == rx_crc);
          crc_err_d = (tx_crc != rx_crc);
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      buf_q       <= '0;
      word_left_q <= '0;
      bit_cnt_q   <= '0;
      verify_q    <= 1'b0;
      prog_en_q   <= 1'b0;
      prog_in_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      word_left_q <= word_left_d;
      bit_cnt_q   <= bit_cnt_d;
      verify_q    <= verify_d;
      prog_en_q   <= prog_en_d;
      prog_in_q   <= prog_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
    end
  end

  prog_crc16 u_tx_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (state_q == ST_SHIFT),
    .bit_in (prog_in_q),
    .crc    (tx_crc)
  );

  prog_crc16 u_rx_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (state_q == ST_VERIFY),
    .bit_in (prog_out),
    .crc    (rx_crc)
  );

  // Loopback must be same-cycle: a register in the path would make the ring
  // CHAIN_LEN+1 long and CHAIN_LEN rotations would no longer restore it.
  assign prog_in = (state_q == ST_VERIFY) ? prog_out : prog_in_q;
  assign prog_en = prog_en_q;
  assign s_ready = (state_q == ST_FETCH);
  assign busy    = busy_q;
  assign done    = done_q;
  assign crc_ok  = crc_ok_q;
  assign crc_err = crc_err_q;

endmodule
